serial_frame_rx: RTL and testbench

Serial frame receiver sitting directly downstream of the `test` bit-stream generator: it consumes the one-bit `dout` stream (one bit per `clk`), frames it, and delivers parallel words with a one-cycle valid strobe. It also flags parity and framing errors and keeps a running count of good frames for lab observation on the waveform.

---
 rtl/serial_frame_rx.sv | 83 ++++++++
 tb/tb_serial_frame_rx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, even parity, stop(1).
// Delivers the parallel word with a one-cycle valid strobe and counts good-stop frames.
module serial_frame_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!din) begin
                        state <= DATA;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    shreg[idx] <= din;
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        state <= PARITY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PARITY: begin
                    par_bit <= din;
                    state   <= STOP;
                end
                STOP: begin
                    // A zero stop bit is never reused as a start bit; IDLE waits for a later 0.
                    if (din) begin
                        data_out   <= shreg;
                        valid      <= 1'b1;
                        parity_err <= par_bit ^ (^shreg);
                        frame_cnt  <= frame_cnt + 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: reset, delivery, back-to-back, parity/framing errors,
// mid-frame reset and counter wrap, each checked with an immediate assertion.
module tb_serial_frame_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              din;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let it be sampled, then settle 1 time unit past the edge.
    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    // Full frame; parity is flipped from even when flip=1. Checks timing of the strobe.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic flip, input logic stop,
                              input string tag);
        int k;
        send_bit(1'b0);
        k = cyc;
        check({tag, "_busy_rise"}, busy, 1);
        for (int unsigned i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit((^d) ^ flip);
        check({tag, "_no_early_valid"}, valid, 0);
        send_bit(stop);
        check({tag, "_stop_edge"}, cyc - k, DATA_W + 2);
        check({tag, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;

        // Reset held with din toggling
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        check("rst_data", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);

        // Release with idle line: no pulses, no activity
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
            check("idle_quiet", {valid, frame_err, busy}, 0);
        end

        // Single frame 0xA5
        send_frame(8'hA5, 1'b0, 1'b1, "a5");
        check("a5_valid", valid, 1);
        check("a5_data", data_out, 8'hA5);
        check("a5_perr", parity_err, 0);
        check("a5_cnt", frame_cnt, 1);
        send_bit(1'b1);
        check("a5_valid_one_cycle", valid, 0);
        check("a5_data_held", data_out, 8'hA5);

        // Back-to-back 0x3C then 0xFF, no idle bit
        begin
            int c1;
            send_frame(8'h3C, 1'b0, 1'b1, "b2b1");
            c1 = cyc;
            check("b2b1_valid", valid, 1);
            check("b2b1_data", data_out, 8'h3C);
            send_frame(8'hFF, 1'b0, 1'b1, "b2b2");
            check("b2b2_valid", valid, 1);
            check("b2b2_data", data_out, 8'hFF);
            check("b2b_spacing", cyc - c1, 11);
            check("b2b_cnt", frame_cnt, 3);
        end
        send_bit(1'b1);

        // Parity error: 0x01 with parity 0
        send_frame(8'h01, 1'b1, 1'b1, "perr");
        check("perr_valid", valid, 1);
        check("perr_flag", parity_err, 1);
        check("perr_data", data_out, 8'h01);
        check("perr_cnt", frame_cnt, 4);
        send_bit(1'b1);

        // Framing error: 0x55 with stop 0
        send_frame(8'h55, 1'b0, 1'b0, "ferr");
        check("ferr_flag", frame_err, 1);
        check("ferr_valid", valid, 0);
        check("ferr_data_kept", data_out, 8'h01);
        check("ferr_cnt_kept", frame_cnt, 4);
        send_bit(1'b1);
        check("ferr_one_pulse", frame_err, 0);
        check("ferr_stop_not_start", busy, 0);
        send_frame(8'h12, 1'b0, 1'b1, "after_ferr");
        check("x12_valid", valid, 1);
        check("x12_data", data_out, 8'h12);
        check("x12_perr", parity_err, 0);
        check("x12_cnt", frame_cnt, 5);
        send_bit(1'b1);

        // Reset after start + 4 data bits of 0xF0
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cnt", frame_cnt, 0);
        check("abort_data", data_out, 0);
        din = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            check("abort_no_pulse", {valid, frame_err, busy}, 0);
        end
        send_frame(8'h81, 1'b0, 1'b1, "x81");
        check("x81_valid", valid, 1);
        check("x81_data", data_out, 8'h81);
        check("x81_cnt", frame_cnt, 1);

        // Counter wrap: 254 more -> 255, one more -> 0
        for (int i = 0; i < 254; i++) send_frame(i[7:0], 1'b0, 1'b1, "wrap_fill");
        check("wrap_cnt_max", frame_cnt, 255);
        send_frame(8'h6B, 1'b0, 1'b1, "wrap_last");
        check("wrap_valid", valid, 1);
        check("wrap_data", data_out, 8'h6B);
        check("wrap_cnt_zero", frame_cnt, 0);
        send_bit(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
